// File: rtl/alu_serial_if.sv
// rtl/alu_serial_if.sv - start/busy/done request and result bundle for the bit-serial ALU
//
// Ports carried (direction seen from the ALU, i.e. the slave modport):
//   start_i     in   request, sampled only while the engine is idle
//   src1_i      in   operand A, latched on an accepted start
//   src2_i      in   operand B, latched on an accepted start
//   ctrl_i      in   {A_invert, B_invert, operation[1:0]}
//   busy_o      out  operation in progress
//   done_o      out  one-cycle completion pulse
//   result_o    out  result, cleared on an accepted start
//   zero_o      out  result == 0
//   cout_o      out  carry out of the MSB slice
//   overflow_o  out  signed overflow
interface alu_serial_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [3:0]       ctrl_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             cout_o;
    logic             overflow_o;

    modport master (
        output start_i, src1_i, src2_i, ctrl_i,
        input  busy_o, done_o, result_o, zero_o, cout_o, overflow_o
    );

    modport slave (
        input  start_i, src1_i, src2_i, ctrl_i,
        output busy_o, done_o, result_o, zero_o, cout_o, overflow_o
    );
endinterface

// File: rtl/alu_serial.sv
// rtl/alu_serial.sv - bit-serial ALU engine, one 1-bit ALU slice per clock, LSB first
//
// Ports:
//   clk_i   in   clock, rising edge
//   rst_i   in   synchronous active-low reset
//   bus     alu_serial_if.slave: start/operands/ctrl in, busy/done/result/flags out
module alu_serial #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    alu_serial_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_src1;
    logic [WIDTH-1:0] r_src2;
    logic [3:0]       r_ctrl;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;
    logic             r_zero;
    logic             r_cout;
    logic             r_ovf;

    logic             w_a;
    logic             w_b;
    logic             w_sum;
    logic             w_carry_next;
    logic             w_is_arith;
    logic             w_last;
    logic             w_ovf;
    logic             w_res_bit;
    logic [WIDTH-1:0] w_result_next;

    // Current slice inputs, with the optional inversions applied.
    assign w_a          = r_src1[r_cnt] ^ r_ctrl[3];
    assign w_b          = r_src2[r_cnt] ^ r_ctrl[2];
    assign w_sum        = w_a ^ w_b ^ r_carry;
    assign w_carry_next = (w_a & w_b) | (w_a & r_carry) | (w_b & r_carry);
    assign w_is_arith   = r_ctrl[1];
    assign w_last       = (r_cnt == LAST_BIT);
    // Only meaningful on the MSB slice: carry into vs. carry out of the sign bit.
    assign w_ovf        = w_is_arith & (r_carry ^ w_carry_next);

    always_comb begin
        w_res_bit = 1'b0;
        case (r_ctrl[1:0])
            2'b00:   w_res_bit = w_a & w_b;
            2'b01:   w_res_bit = w_a | w_b;
            2'b10:   w_res_bit = w_sum;
            default: w_res_bit = 1'b0;
        endcase

        w_result_next        = r_result;
        w_result_next[r_cnt] = w_res_bit;
        // SLT: the set bit is the overflow-corrected sign of the difference,
        // known only once the MSB slice has been evaluated.
        if (w_last && (r_ctrl[1:0] == 2'b11)) begin
            w_result_next[0] = w_sum ^ w_ovf;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state  <= IDLE;
            r_src1   <= '0;
            r_src2   <= '0;
            r_ctrl   <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_zero   <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start_i) begin
                        r_src1   <= bus.src1_i;
                        r_src2   <= bus.src2_i;
                        r_ctrl   <= bus.ctrl_i;
                        r_cnt    <= '0;
                        // B_invert supplies the +1 of the two's-complement subtract.
                        r_carry  <= bus.ctrl_i[2];
                        r_result <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_result <= w_result_next;
                    r_carry  <= w_carry_next;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_cout  <= w_is_arith & w_carry_next;
                        r_ovf   <= w_ovf;
                        r_zero  <= (w_result_next == '0);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy_o     = r_busy;
    assign bus.done_o     = r_done;
    assign bus.result_o   = r_result;
    assign bus.zero_o     = r_zero;
    assign bus.cout_o     = r_cout;
    assign bus.overflow_o = r_ovf;

endmodule

// File: tb/tb_alu_serial.sv
// tb/tb_alu_serial.sv - directed self-checking bench for alu_serial
module tb_alu_serial;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   lat;

    alu_serial_if #(.WIDTH(32)) bus ();

    alu_serial #(.WIDTH(32), .CNT_W(5)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for exactly one edge (E0).
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        bus.src1_i  = a;
        bus.src2_i  = b;
        bus.ctrl_i  = c;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
    endtask

    // Called just after E0; returns the clock period (1 = period right after E0)
    // in which done_o is seen, or 100 if it never comes.
    task automatic wait_done(output int n);
        n = 1;
        while (!bus.done_o && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        start_op(a, b, c);
        wait_done(lat);
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst         = 1'b0;
        bus.start_i = 1'b0;
        bus.src1_i  = '0;
        bus.src2_i  = '0;
        bus.ctrl_i  = '0;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_result", bus.result_o, 32'd0);
        check("rst_flags", {29'd0, bus.zero_o, bus.cout_o, bus.overflow_o}, 32'd0);
        rst = 1'b1;
        tick();

        // ADD with signed overflow
        start_op(32'h7FFF_FFFF, 32'h0000_0001, 4'b0010);
        check("add_busy", 32'(bus.busy_o), 32'd1);
        wait_done(lat);
        check("add_latency", lat, 32'd33);
        check("add_result", bus.result_o, 32'h8000_0000);
        check("add_flags", {29'd0, bus.zero_o, bus.cout_o, bus.overflow_o}, 32'b001);
        check("add_busy_end", 32'(bus.busy_o), 32'd0);
        tick();
        check("done_one_cycle", 32'(bus.done_o), 32'd0);
        check("result_hold", bus.result_o, 32'h8000_0000);

        // SUB 5-5
        run_op(32'd5, 32'd5, 4'b0110);
        check("sub_result", bus.result_o, 32'd0);
        check("sub_flags", {29'd0, bus.zero_o, bus.cout_o, bus.overflow_o}, 32'b110);
        tick();

        // SLT -1 < 1
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 4'b0111);
        check("slt_neg_result", bus.result_o, 32'd1);
        check("slt_neg_ovf", 32'(bus.overflow_o), 32'd0);
        tick();

        // SLT with overflow correction
        run_op(32'h8000_0000, 32'h7FFF_FFFF, 4'b0111);
        check("slt_ovf_result", bus.result_o, 32'd1);
        check("slt_ovf_flag", 32'(bus.overflow_o), 32'd1);
        tick();

        // SLT reversed
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 4'b0111);
        check("slt_rev_result", bus.result_o, 32'd0);
        check("slt_rev_zero", 32'(bus.zero_o), 32'd1);
        tick();

        // NOR
        run_op(32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'b1100);
        check("nor_result", bus.result_o, 32'd0);
        check("nor_flags", {29'd0, bus.zero_o, bus.cout_o, bus.overflow_o}, 32'b100);
        tick();

        // OR
        run_op(32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'b0001);
        check("or_result", bus.result_o, 32'hFFFF_FFFF);
        check("or_flags", {29'd0, bus.zero_o, bus.cout_o, bus.overflow_o}, 32'b000);
        tick();

        // Start pulsed mid-run with different operands is ignored
        start_op(32'h1234_5678, 32'h1111_1111, 4'b0010);
        for (int i = 2; i < 10; i++) tick();
        bus.src1_i  = 32'd1;
        bus.src2_i  = 32'd1;
        bus.ctrl_i  = 4'b0000;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        lat = 10;
        while (!bus.done_o && lat < 100) begin
            tick();
            lat++;
        end
        check("ign_latency", lat, 32'd33);
        check("ign_result", bus.result_o, 32'h2345_6789);

        // Start accepted in the done cycle
        start_op(32'hFF00_FF00, 32'h0FF0_0FF0, 4'b0000);
        check("b2b_cleared", bus.result_o, 32'd0);
        check("b2b_busy", 32'(bus.busy_o), 32'd1);
        wait_done(lat);
        check("b2b_latency", lat, 32'd33);
        check("b2b_result", bus.result_o, 32'h0F00_0F00);
        tick();

        // Reset mid-run aborts
        start_op(32'hAAAA_AAAA, 32'h1111_1111, 4'b0010);
        for (int i = 2; i < 15; i++) tick();
        rst = 1'b0;
        tick();
        check("abort_busy", 32'(bus.busy_o), 32'd0);
        check("abort_result", bus.result_o, 32'd0);
        check("abort_done", 32'(bus.done_o), 32'd0);
        rst = 1'b1;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done_o) lat++;
        end
        check("abort_no_done", lat, 32'd0);
        run_op(32'd3, 32'd4, 4'b0010);
        check("post_rst_latency", lat, 32'd33);
        check("post_rst_result", bus.result_o, 32'd7);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
